// File: rtl/sobel_pkg.sv
// Shared definitions for the multi-channel Sobel edge detector.
package sobel_pkg;

   // Output formatting modes, captured once per frame.
   typedef enum logic [1:0] {
      MODE_OR     = 2'd0,
      MODE_PER_CH = 2'd1,
      MODE_MAG    = 2'd2,
      MODE_BYPASS = 2'd3
   } mode_t;

   // Input-to-output latency in clocks for data and syncs.
   localparam int PIPE = 4;

   // Gradient/magnitude width: |Gx|+|Gy| never exceeds 8*(2^pix_w-1).
   function automatic int mag_width(input int pix_w);
      return pix_w + 3;
   endfunction

endpackage

// File: rtl/sobel_kernel.sv
// One colour channel of the Sobel operator: gradients (S2) and magnitude (S3).
module sobel_kernel
   import sobel_pkg::*;
#(
   parameter int PIX_W = 8
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [9*PIX_W-1:0]            win,
   output logic [mag_width(PIX_W)-1:0]   mag
);

   localparam int MW = mag_width(PIX_W);

   // Window taps: win[(r*3+k)*PIX_W] with row 0 oldest line, column 0 leftmost.
   logic signed [MW-1:0] tap [3][3];
   logic signed [MW-1:0] gx_nxt, gy_nxt;
   logic signed [MW-1:0] gx_p2, gy_p2;
   logic        [MW-1:0] mag_p3;

   function automatic logic signed [MW-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({{(MW-PIX_W){1'b0}}, p});
   endfunction

   function automatic logic [MW-1:0] abs_val(input logic signed [MW-1:0] v);
      return v[MW-1] ? $unsigned(-v) : $unsigned(v);
   endfunction

   // Unpack the flattened window into signed taps.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 3; k++) begin
            tap[r][k] = ext(win[(r*3+k)*PIX_W +: PIX_W]);
         end
      end
   end

   assign gx_nxt = (tap[0][2] + (tap[1][2] <<< 1) + tap[2][2])
                 - (tap[0][0] + (tap[1][0] <<< 1) + tap[2][0]);
   assign gy_nxt = (tap[2][0] + (tap[2][1] <<< 1) + tap[2][2])
                 - (tap[0][0] + (tap[0][1] <<< 1) + tap[0][2]);

   // S2 gradient register, S3 magnitude register.
   always_ff @(posedge clk) begin
      if (rst) begin
         gx_p2  <= '0;
         gy_p2  <= '0;
         mag_p3 <= '0;
      end else begin
         gx_p2  <= gx_nxt;
         gy_p2  <= gy_nxt;
         mag_p3 <= abs_val(gx_p2) + abs_val(gy_p2);
      end
   end

   assign mag = mag_p3;

endmodule

// File: rtl/sobel_multi.sv
// Multi-channel 3x3 Sobel edge detector with line stores, sync alignment and
// selectable output formatting. Output is centred one row up, one column left.
module sobel_multi
   import sobel_pkg::*;
#(
   parameter int CHANNELS       = 3,
   parameter int PIX_W          = 8,
   parameter int MAX_LINE_WIDTH = 2100,
   parameter int THRESH_DEFAULT = 400
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CHANNELS*PIX_W-1:0]    pix_in,
   input  logic                         hsync,
   input  logic                         vsync,
   input  logic                         de,
   input  logic [PIX_W+2:0]             threshold,
   input  logic [1:0]                   mode,
   output logic [CHANNELS*PIX_W-1:0]    edge_out,
   output logic                         hsync_out,
   output logic                         vsync_out,
   output logic                         de_out,
   output logic                         overflow
);

   localparam int MW = mag_width(PIX_W);
   localparam int DW = CHANNELS * PIX_W;
   localparam int CW = $clog2(MAX_LINE_WIDTH + 1);
   localparam logic [CW-1:0] COL_MAX = CW'(MAX_LINE_WIDTH);

   // Control state
   logic [CW-1:0] col_cnt;
   logic [1:0]    row_cnt;
   logic          de_d, vsync_d;
   mode_t         mode_r;
   logic [MW-1:0] thr_r;

   logic          vs_rise, de_fall, col_ovf, win_vld;
   logic [CW-1:0] rd_addr;

   // Line stores (row y-1 in line0, row y-2 in line1); contents are never reset
   logic [DW-1:0] line0 [MAX_LINE_WIDTH];
   logic [DW-1:0] line1 [MAX_LINE_WIDTH];
   logic [DW-1:0] up1, up2;

   // Pipeline state
   logic [PIX_W-1:0] win_p1 [CHANNELS][3][3];
   logic [DW-1:0]    pix_p1, pix_p2, pix_p3;
   logic             vld_p1, vld_p2, vld_p3;
   logic             kill_p1, kill_p2, kill_p3;
   logic             hsync_p1, hsync_p2, hsync_p3;
   logic             vsync_p1, vsync_p2, vsync_p3;
   logic             de_p1, de_p2, de_p3;
   logic [MW-1:0]    mag_p3 [CHANNELS];

   logic [CHANNELS-1:0] hit;
   logic                any_hit;
   logic [DW-1:0]       edge_nxt;

   function automatic logic [PIX_W-1:0] sat_pix(input logic [MW-1:0] m);
      if (m > MW'((1 << PIX_W) - 1)) return '1;
      return m[PIX_W-1:0];
   endfunction

   assign vs_rise = vsync & ~vsync_d;
   assign de_fall = de_d & ~de;
   assign col_ovf = de && (col_cnt == COL_MAX);
   assign win_vld = de && (row_cnt == 2'd2) && (col_cnt >= CW'(2)) && !col_ovf;
   assign rd_addr = (col_cnt == COL_MAX) ? '0 : col_cnt;
   assign up1     = line0[rd_addr];
   assign up2     = line1[rd_addr];

   // Position counters, per-frame mode/threshold capture and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt  <= '0;
         row_cnt  <= '0;
         de_d     <= 1'b0;
         vsync_d  <= 1'b0;
         mode_r   <= MODE_OR;
         thr_r    <= MW'(THRESH_DEFAULT);
         overflow <= 1'b0;
      end else begin
         de_d    <= de;
         vsync_d <= vsync;
         // col_cnt parks at COL_MAX so an over-long line never wraps the address
         if (!de)                   col_cnt <= '0;
         else if (col_cnt != COL_MAX) col_cnt <= col_cnt + CW'(1);
         if (vs_rise)                        row_cnt <= '0;
         else if (de_fall && row_cnt != 2'd2) row_cnt <= row_cnt + 2'd1;
         if (vs_rise) begin
            mode_r <= mode_t'(mode);
            thr_r  <= threshold;
         end
         if (col_ovf) overflow <= 1'b1;
      end
   end

   // Line store update: push current pixel down, suppressed past the store depth.
   always_ff @(posedge clk) begin
      if (de && !col_ovf) begin
         line0[rd_addr] <= pix_in;
         line1[rd_addr] <= line0[rd_addr];
      end
   end

   // S1: shift the 3x3 window left and load the new column.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++)
            for (int r = 0; r < 3; r++)
               for (int k = 0; k < 3; k++)
                  win_p1[c][r][k] <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int r = 0; r < 3; r++) begin
               win_p1[c][r][0] <= win_p1[c][r][1];
               win_p1[c][r][1] <= win_p1[c][r][2];
            end
            win_p1[c][0][2] <= up2[c*PIX_W +: PIX_W];
            win_p1[c][1][2] <= up1[c*PIX_W +: PIX_W];
            win_p1[c][2][2] <= pix_in[c*PIX_W +: PIX_W];
         end
      end
   end

   // S1..S3: control, syncs and bypass pixel travel alongside the kernel.
   always_ff @(posedge clk) begin
      if (rst) begin
         {vld_p1, vld_p2, vld_p3}       <= '0;
         {kill_p1, kill_p2, kill_p3}    <= '0;
         {hsync_p1, hsync_p2, hsync_p3} <= '0;
         {vsync_p1, vsync_p2, vsync_p3} <= '0;
         {de_p1, de_p2, de_p3}          <= '0;
         pix_p1 <= '0;
         pix_p2 <= '0;
         pix_p3 <= '0;
      end else begin
         vld_p1   <= win_vld;   vld_p2   <= vld_p1;   vld_p3   <= vld_p2;
         kill_p1  <= col_ovf;   kill_p2  <= kill_p1;  kill_p3  <= kill_p2;
         hsync_p1 <= hsync;     hsync_p2 <= hsync_p1; hsync_p3 <= hsync_p2;
         vsync_p1 <= vsync;     vsync_p2 <= vsync_p1; vsync_p3 <= vsync_p2;
         de_p1    <= de;        de_p2    <= de_p1;    de_p3    <= de_p2;
         pix_p1   <= pix_in;    pix_p2   <= pix_p1;   pix_p3   <= pix_p2;
      end
   end

   // S2..S3: one kernel per channel
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [9*PIX_W-1:0] win_flat;
      for (genvar r = 0; r < 3; r++) begin : g_row
         for (genvar k = 0; k < 3; k++) begin : g_col
            assign win_flat[(r*3+k)*PIX_W +: PIX_W] = win_p1[c][r][k];
         end
      end
      sobel_kernel #(.PIX_W(PIX_W)) u_kernel (
         .clk (clk),
         .rst (rst),
         .win (win_flat),
         .mag (mag_p3[c])
      );
   end

   // S4 formatting: threshold/saturate per mode, blank outside active or valid pixels.
   always_comb begin
      hit      = '0;
      edge_nxt = '0;
      for (int c = 0; c < CHANNELS; c++) hit[c] = mag_p3[c] > thr_r;
      any_hit = |hit;
      case (mode_r)
         MODE_OR:     edge_nxt = any_hit ? '1 : '0;
         MODE_PER_CH: for (int c = 0; c < CHANNELS; c++)
                         edge_nxt[c*PIX_W +: PIX_W] = hit[c] ? '1 : '0;
         MODE_MAG:    for (int c = 0; c < CHANNELS; c++)
                         edge_nxt[c*PIX_W +: PIX_W] = sat_pix(mag_p3[c]);
         MODE_BYPASS: edge_nxt = pix_p3;
         default:     edge_nxt = '0;
      endcase
      if (!de_p3 || kill_p3 || (mode_r != MODE_BYPASS && !vld_p3)) edge_nxt = '0;
   end

   // S4 output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_out  <= '0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
         de_out    <= 1'b0;
      end else begin
         edge_out  <= edge_nxt;
         hsync_out <= hsync_p3;
         vsync_out <= vsync_p3;
         de_out    <= de_p3;
      end
   end

endmodule

// File: tb/tb_sobel_multi.sv
// Directed testbench for sobel_multi with hand-derived expectations.
module tb_sobel_multi;
   import sobel_pkg::*;

   localparam int MAXW = 2100;
   localparam int LOG  = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] pix_in;
   logic        hsync, vsync, de;
   logic [10:0] threshold;
   logic [1:0]  mode;
   logic [23:0] edge_out;
   logic        hsync_out, vsync_out, de_out, overflow;

   int errors = 0;
   int checks = 0;

   logic [23:0] in_pix [LOG];
   logic        in_h [LOG], in_v [LOG], in_d [LOG];
   int          in_row [LOG], in_col [LOG];
   logic [23:0] out_edge [LOG];
   logic        out_h [LOG], out_v [LOG], out_d [LOG], out_ovf [LOG];
   int n = 0;
   int cur_row = -1;
   int cur_col = -1;

   sobel_multi #(
      .CHANNELS(3), .PIX_W(8), .MAX_LINE_WIDTH(MAXW), .THRESH_DEFAULT(400)
   ) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .hsync(hsync), .vsync(vsync), .de(de),
      .threshold(threshold), .mode(mode), .edge_out(edge_out), .hsync_out(hsync_out),
      .vsync_out(vsync_out), .de_out(de_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Apply one cycle of input, then log outputs of the following cycle.
   task automatic drive(input logic [23:0] p, input logic h, input logic v, input logic d);
      pix_in = p; hsync = h; vsync = v; de = d;
      if (n < LOG - 1) begin
         in_pix[n] = p; in_h[n] = h; in_v[n] = v; in_d[n] = d;
         in_row[n] = cur_row; in_col[n] = cur_col;
      end
      @(posedge clk); #1;
      n++;
      if (n < LOG) begin
         out_edge[n] = edge_out; out_h[n] = hsync_out; out_v[n] = vsync_out;
         out_d[n] = de_out; out_ovf[n] = overflow;
      end
   endtask

   function automatic logic [23:0] pat_pix(input int pat, input int x, input int y);
      case (pat)
         0:       return 24'h646464;
         1:       return (x >= 4) ? 24'h0000FF : 24'h000000;
         2:       return (x >= 4) ? 24'h000014 : 24'h000000;
         3:       return (x >= 4) ? 24'h000064 : 24'h000000;
         default: return {8'(x*3 + y), 8'(x + 16), 8'(x) | 8'h01};
      endcase
   endfunction

   // Vertical step at x=4: windows at input columns 4 and 5 straddle it, from row 2.
   function automatic logic [23:0] step_exp(input int k, input logic [23:0] hitval);
      if (in_d[k] && in_row[k] >= 2 && (in_col[k] == 4 || in_col[k] == 5)) return hitval;
      return 24'h0;
   endfunction

   task automatic frame(input int w, input int h, input int pat,
                        input logic [10:0] thr_a, input logic [10:0] thr_b,
                        input logic [1:0] md);
      n = 0; threshold = thr_a; mode = md; cur_row = -1; cur_col = -1;
      drive(24'h0, 0, 1, 0); drive(24'h0, 0, 1, 0);
      drive(24'h0, 0, 0, 0); drive(24'h0, 0, 0, 0);
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            cur_row = y; cur_col = x;
            drive(pat_pix(pat, x, y), 0, 0, 1);
         end
         cur_row = -1; cur_col = -1;
         if (y == 0) threshold = thr_b;
         drive(24'h0, 1, 0, 0); drive(24'h0, 1, 0, 0);
         drive(24'h0, 0, 0, 0); drive(24'h0, 0, 0, 0);
      end
      repeat (6) drive(24'h0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 2'd0; threshold = 11'd400;
      repeat (3) drive(24'h0, 0, 0, 0);
      checks++; if (edge_out !== 24'h0) begin errors++; $display("FAIL reset_edge got=%h exp=000000", edge_out); end
      checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL reset_de got=%b exp=0", de_out); end
      checks++; if (hsync_out !== 1'b0) begin errors++; $display("FAIL reset_hsync got=%b exp=0", hsync_out); end
      checks++; if (vsync_out !== 1'b0) begin errors++; $display("FAIL reset_vsync got=%b exp=0", vsync_out); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
      rst = 1'b0;
   endtask

   task automatic test_flat();
      frame(8, 4, 0, 11'd400, 11'd400, 2'd0);
      for (int k = 0; k + PIPE <= n; k++) begin
         checks++; if (out_edge[k+PIPE] !== 24'h0) begin errors++; $display("FAIL flat_edge k=%0d got=%h exp=000000", k, out_edge[k+PIPE]); end
         checks++; if (out_h[k+PIPE] !== in_h[k]) begin errors++; $display("FAIL flat_hsync k=%0d got=%b exp=%b", k, out_h[k+PIPE], in_h[k]); end
         checks++; if (out_v[k+PIPE] !== in_v[k]) begin errors++; $display("FAIL flat_vsync k=%0d got=%b exp=%b", k, out_v[k+PIPE], in_v[k]); end
         checks++; if (out_d[k+PIPE] !== in_d[k]) begin errors++; $display("FAIL flat_de k=%0d got=%b exp=%b", k, out_d[k+PIPE], in_d[k]); end
      end
   endtask

   task automatic test_step();
      frame(8, 4, 1, 11'd400, 11'd400, 2'd1);
      for (int k = 0; k + PIPE <= n; k++) begin
         checks++; if (out_edge[k+PIPE] !== step_exp(k, 24'h0000FF)) begin errors++; $display("FAIL step_perch k=%0d got=%h exp=%h", k, out_edge[k+PIPE], step_exp(k, 24'h0000FF)); end
      end
      frame(8, 4, 1, 11'd400, 11'd400, 2'd0);
      for (int k = 0; k + PIPE <= n; k++) begin
         checks++; if (out_edge[k+PIPE] !== step_exp(k, 24'hFFFFFF)) begin errors++; $display("FAIL step_or k=%0d got=%h exp=%h", k, out_edge[k+PIPE], step_exp(k, 24'hFFFFFF)); end
      end
   endtask

   task automatic test_mag();
      frame(8, 4, 1, 11'd400, 11'd400, 2'd2);
      for (int k = 0; k + PIPE <= n; k++) begin
         checks++; if (out_edge[k+PIPE] !== step_exp(k, 24'h0000FF)) begin errors++; $display("FAIL mag_sat k=%0d got=%h exp=%h", k, out_edge[k+PIPE], step_exp(k, 24'h0000FF)); end
      end
      frame(8, 4, 2, 11'd400, 11'd400, 2'd2);
      for (int k = 0; k + PIPE <= n; k++) begin
         checks++; if (out_edge[k+PIPE] !== step_exp(k, 24'h000050)) begin errors++; $display("FAIL mag_small k=%0d got=%h exp=%h", k, out_edge[k+PIPE], step_exp(k, 24'h000050)); end
      end
   endtask

   task automatic test_threshold_boundary();
      frame(8, 4, 3, 11'd400, 11'd400, 2'd0);
      for (int k = 0; k + PIPE <= n; k++) begin
         checks++; if (out_edge[k+PIPE] !== 24'h0) begin errors++; $display("FAIL thr_equal k=%0d got=%h exp=000000", k, out_edge[k+PIPE]); end
      end
      frame(8, 4, 3, 11'd399, 11'd399, 2'd0);
      for (int k = 0; k + PIPE <= n; k++) begin
         checks++; if (out_edge[k+PIPE] !== step_exp(k, 24'hFFFFFF)) begin errors++; $display("FAIL thr_below k=%0d got=%h exp=%h", k, out_edge[k+PIPE], step_exp(k, 24'hFFFFFF)); end
      end
   endtask

   task automatic test_thr_midframe();
      frame(8, 4, 3, 11'd400, 11'd399, 2'd0);
      for (int k = 0; k + PIPE <= n; k++) begin
         checks++; if (out_edge[k+PIPE] !== 24'h0) begin errors++; $display("FAIL thr_mid_old k=%0d got=%h exp=000000", k, out_edge[k+PIPE]); end
      end
      frame(8, 4, 3, 11'd399, 11'd399, 2'd0);
      for (int k = 0; k + PIPE <= n; k++) begin
         checks++; if (out_edge[k+PIPE] !== step_exp(k, 24'hFFFFFF)) begin errors++; $display("FAIL thr_mid_new k=%0d got=%h exp=%h", k, out_edge[k+PIPE], step_exp(k, 24'hFFFFFF)); end
      end
   endtask

   task automatic test_bypass();
      logic [23:0] exp;
      frame(8, 4, 4, 11'd400, 11'd400, 2'd3);
      for (int k = 0; k + PIPE <= n; k++) begin
         exp = in_d[k] ? in_pix[k] : 24'h0;
         checks++; if (out_edge[k+PIPE] !== exp) begin errors++; $display("FAIL bypass k=%0d got=%h exp=%h", k, out_edge[k+PIPE], exp); end
      end
   endtask

   task automatic test_overflow();
      logic [23:0] exp;
      frame(MAXW + 5, 1, 4, 11'd400, 11'd400, 2'd3);
      for (int k = 0; k + PIPE <= n; k++) begin
         exp = (in_d[k] && in_col[k] < MAXW) ? in_pix[k] : 24'h0;
         checks++; if (out_edge[k+PIPE] !== exp) begin errors++; $display("FAIL ovf_data k=%0d col=%0d got=%h exp=%h", k, in_col[k], out_edge[k+PIPE], exp); end
         if (in_col[k] == MAXW) begin
            checks++; if (out_ovf[k] !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", out_ovf[k]); end
            checks++; if (out_ovf[k+1] !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", out_ovf[k+1]); end
         end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_reset_midframe();
      int n_rst;
      n = 0; mode = 2'd3; threshold = 11'd400; cur_row = -1; cur_col = -1;
      drive(24'h0, 0, 1, 0); drive(24'h0, 0, 1, 0);
      drive(24'h0, 0, 0, 0); drive(24'h0, 0, 0, 0);
      cur_row = 0;
      for (int x = 0; x < 5; x++) begin cur_col = x; drive(pat_pix(4, x, 0), 0, 0, 1); end
      checks++; if (de_out !== 1'b1) begin errors++; $display("FAIL pre_rst_de got=%b exp=1", de_out); end
      checks++; if (edge_out !== pat_pix(4, 1, 0)) begin errors++; $display("FAIL pre_rst_edge got=%h exp=%h", edge_out, pat_pix(4, 1, 0)); end
      rst = 1'b1;
      cur_col = 5; drive(pat_pix(1, 5, 0), 0, 0, 1);
      rst = 1'b0;
      n_rst = n;
      checks++; if (edge_out !== 24'h0) begin errors++; $display("FAIL rst_edge got=%h exp=000000", edge_out); end
      checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL rst_de got=%b exp=0", de_out); end
      checks++; if (hsync_out !== 1'b0) begin errors++; $display("FAIL rst_hsync got=%b exp=0", hsync_out); end
      checks++; if (vsync_out !== 1'b0) begin errors++; $display("FAIL rst_vsync got=%b exp=0", vsync_out); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
      for (int x = 6; x < 8; x++) begin cur_col = x; drive(pat_pix(1, x, 0), 0, 0, 1); end
      cur_row = -1; cur_col = -1;
      drive(24'h0, 1, 0, 0); drive(24'h0, 1, 0, 0); drive(24'h0, 0, 0, 0); drive(24'h0, 0, 0, 0);
      cur_row = 1;
      for (int x = 0; x < 8; x++) begin cur_col = x; drive(pat_pix(1, x, 1), 0, 0, 1); end
      cur_row = -1; cur_col = -1;
      drive(24'h0, 1, 0, 0); drive(24'h0, 1, 0, 0);
      repeat (6) drive(24'h0, 0, 0, 0);
      for (int i = n_rst + 1; i <= n_rst + 3; i++) begin
         checks++; if (out_d[i] !== 1'b0) begin errors++; $display("FAIL rst_pipe_de i=%0d got=%b exp=0", i, out_d[i]); end
      end
      for (int i = n_rst; i <= n; i++) begin
         checks++; if (out_edge[i] !== 24'h0) begin errors++; $display("FAIL rst_zero i=%0d got=%h exp=000000", i, out_edge[i]); end
      end
   endtask

   initial begin
      rst = 1'b1; pix_in = '0; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
      threshold = 11'd400; mode = 2'd0;
      test_reset();
      test_flat();
      test_step();
      test_mag();
      test_threshold_boundary();
      test_thr_midframe();
      test_bypass();
      test_overflow();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
